// File: rtl/hamming74_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hamming74_pkg
// Description : Shared definitions for the Hamming(7,4) serial encoder and
//               decoder: FSM state type, codeword width and the bit map that
//               places data and parity bits inside the 7-bit codeword.
//               Both link ends import this package so they agree on one map.
// Revision    : 1.0 - initial release
// ============================================================================
package hamming74_pkg;

    // Transmitter frame sequencing states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GUARD = 2'd2
    } state_t;

    // Codeword width.
    localparam int unsigned CW_BITS = 7;

    // Data-bit positions inside the codeword (d0, d1, d2, d3).
    localparam logic [2:0] D0_POS = 3'd0;
    localparam logic [2:0] D1_POS = 3'd1;
    localparam logic [2:0] D2_POS = 3'd2;
    localparam logic [2:0] D3_POS = 3'd4;

    // Parity-bit positions inside the codeword.
    //   P0 covers d0,d1,d2   P1 covers d0,d1,d3   P2 covers d0,d2,d3
    localparam logic [2:0] P0_POS = 3'd3;
    localparam logic [2:0] P1_POS = 3'd5;
    localparam logic [2:0] P2_POS = 3'd6;

    // err_pos value that requests no bit flip.
    localparam logic [2:0] NO_ERR_POS = 3'd7;

endpackage : hamming74_pkg
`default_nettype wire

// File: rtl/hamming74_serial_encoder_if.sv
`default_nettype none
// ============================================================================
// Module      : hamming74_serial_encoder_if
// Description : Nibble handshake, error-injection control and serial output
//               of the Hamming(7,4) serial encoder, bundled as one interface.
//   data_in[3:0]  producer -> encoder  nibble to encode
//   data_valid    producer -> encoder  data_in offered this cycle
//   data_ready    encoder  -> producer encoder can accept this cycle
//   err_en        producer -> encoder  inject a single-bit error this frame
//   err_pos[2:0]  producer -> encoder  codeword bit to flip (7 = none)
//   encode_out    encoder  -> line     serial codeword bit
//   frame_start   encoder  -> line     high while bit 0 is on encode_out
//   busy          encoder  -> line     high in SHIFT or GUARD
//   Modports: slave = encoder side, master = producer/observer side.
// Revision    : 1.0 - initial release
// ============================================================================
interface hamming74_serial_encoder_if;

    logic [3:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic       err_en;
    logic [2:0] err_pos;
    logic       encode_out;
    logic       frame_start;
    logic       busy;

    modport slave (
        input  data_in,
        input  data_valid,
        output data_ready,
        input  err_en,
        input  err_pos,
        output encode_out,
        output frame_start,
        output busy
    );

    modport master (
        output data_in,
        output data_valid,
        input  data_ready,
        output err_en,
        output err_pos,
        input  encode_out,
        input  frame_start,
        input  busy
    );

endinterface : hamming74_serial_encoder_if
`default_nettype wire

// File: rtl/hamming74_encode_comb.sv
`default_nettype none
// ============================================================================
// Module      : hamming74_encode_comb
// Description : Purely combinational Hamming(7,4) codeword former with
//               optional single-bit error injection.
//   i_d[3:0]       nibble to encode
//   i_err_en       flip one codeword bit when high
//   i_err_pos[2:0] bit to flip; 7 leaves the codeword untouched
//   o_cw[6:0]      (possibly corrupted) codeword
// Revision    : 1.0 - initial release
// ============================================================================
module hamming74_encode_comb
    import hamming74_pkg::*;
(
    input  wire logic [3:0]         i_d,
    input  wire logic               i_err_en,
    input  wire logic [2:0]         i_err_pos,
    output logic      [CW_BITS-1:0] o_cw
);

    logic [CW_BITS-1:0] w_cw_clean;
    logic [CW_BITS-1:0] w_flip;

    always_comb begin
        w_cw_clean         = '0;
        w_cw_clean[D0_POS] = i_d[0];
        w_cw_clean[D1_POS] = i_d[1];
        w_cw_clean[D2_POS] = i_d[2];
        w_cw_clean[D3_POS] = i_d[3];
        w_cw_clean[P0_POS] = i_d[0] ^ i_d[1] ^ i_d[2];
        w_cw_clean[P1_POS] = i_d[0] ^ i_d[1] ^ i_d[3];
        w_cw_clean[P2_POS] = i_d[0] ^ i_d[2] ^ i_d[3];
    end

    // One-hot flip mask; position 7 lies outside the codeword and means "none".
    always_comb begin
        w_flip = '0;
        if (i_err_en && (i_err_pos != NO_ERR_POS)) begin
            w_flip[i_err_pos] = 1'b1;
        end
    end

    assign o_cw = w_cw_clean ^ w_flip;

endmodule : hamming74_encode_comb
`default_nettype wire

// File: rtl/hamming74_serial_encoder.sv
`default_nettype none
// ============================================================================
// Module      : hamming74_serial_encoder
// Description : Accepts a nibble over valid/ready, forms the Hamming(7,4)
//               codeword and shifts it out LSB first, one bit per clock,
//               followed by GUARD_BITS idle slots. With GUARD_BITS=1 the
//               frame period is 8 cycles, matching the serial decoder.
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  hamming74_serial_encoder_if.slave (handshake, error control, line)
//   GUARD_BITS  idle slots after bit 6, legal range 1..4
//   IDLE_LEVEL  line level when idle or in a guard slot
// Revision    : 1.0 - initial release
// ============================================================================
module hamming74_serial_encoder
    import hamming74_pkg::*;
#(
    parameter int unsigned GUARD_BITS = 1,
    parameter logic        IDLE_LEVEL = 1'b0
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    hamming74_serial_encoder_if.slave  bus
);

    localparam logic [2:0] c_last_bit   = 3'(CW_BITS - 1);
    localparam logic [1:0] c_guard_last = 2'(GUARD_BITS - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [CW_BITS-1:0] r_sreg;
    logic [CW_BITS-1:0] w_sreg_next;
    logic [2:0]         r_bit_cnt;
    logic [2:0]         w_bit_cnt_next;
    logic [1:0]         r_guard_cnt;
    logic [1:0]         w_guard_cnt_next;
    logic [CW_BITS-1:0] w_cw;
    logic               w_ready;
    logic               w_accept;

    hamming74_encode_comb u_encode (
        .i_d       (bus.data_in),
        .i_err_en  (bus.err_en),
        .i_err_pos (bus.err_pos),
        .o_cw      (w_cw)
    );

    // Ready depends on registered state only, so there is no path from
    // data_valid back to data_ready.
    assign w_ready  = (r_state == IDLE) ||
                      ((r_state == GUARD) && (r_guard_cnt == c_guard_last));
    assign w_accept = w_ready && bus.data_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_sreg      <= '0;
            r_bit_cnt   <= '0;
            r_guard_cnt <= '0;
        end else begin
            r_state     <= w_state_next;
            r_sreg      <= w_sreg_next;
            r_bit_cnt   <= w_bit_cnt_next;
            r_guard_cnt <= w_guard_cnt_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_sreg_next      = r_sreg;
        w_bit_cnt_next   = r_bit_cnt;
        w_guard_cnt_next = r_guard_cnt;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next   = SHIFT;
                    w_sreg_next    = w_cw;
                    w_bit_cnt_next = '0;
                end
            end

            SHIFT: begin
                w_sreg_next = {1'b0, r_sreg[CW_BITS-1:1]};
                if (r_bit_cnt == c_last_bit) begin
                    w_state_next     = GUARD;
                    w_guard_cnt_next = '0;
                end else begin
                    w_bit_cnt_next = r_bit_cnt + 3'd1;
                end
            end

            GUARD: begin
                if (r_guard_cnt == c_guard_last) begin
                    // Final guard slot: a pending nibble starts the next
                    // frame immediately, giving back-to-back frames.
                    if (w_accept) begin
                        w_state_next   = SHIFT;
                        w_sreg_next    = w_cw;
                        w_bit_cnt_next = '0;
                    end else begin
                        w_state_next = IDLE;
                    end
                end else begin
                    w_guard_cnt_next = r_guard_cnt + 2'd1;
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign bus.data_ready  = w_ready;
    assign bus.encode_out  = (r_state == SHIFT) ? r_sreg[0] : IDLE_LEVEL;
    assign bus.frame_start = (r_state == SHIFT) && (r_bit_cnt == 3'd0);
    assign bus.busy        = (r_state != IDLE);

endmodule : hamming74_serial_encoder
`default_nettype wire

// File: tb/tb_hamming74_serial_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_hamming74_serial_encoder
// Description : Self-checking bench for hamming74_serial_encoder. A driver
//               offers nibbles and pushes the expected frame into a
//               scoreboard queue; an independent monitor collects each
//               serial frame and compares it, including a loopback decode.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hamming74_serial_encoder;

    localparam int unsigned GUARD_BITS = 1;
    localparam logic        IDLE_LEVEL = 1'b0;

    typedef struct {
        logic [6:0] cw;
        logic [3:0] data;
        int         start_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    exp_t sb_q[$];

    hamming74_serial_encoder_if bus ();

    hamming74_serial_encoder #(
        .GUARD_BITS (GUARD_BITS),
        .IDLE_LEVEL (IDLE_LEVEL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference encoder: place data bits, then each parity bit is the XOR
    // of the data bits it protects; optionally invert one position.
    function automatic logic [6:0] model_cw(input logic [3:0] d, input logic en, input logic [2:0] pos);
        int         dpos [4] = '{0, 1, 2, 4};
        logic [6:0] c = '0;
        for (int i = 0; i < 4; i++) c[dpos[i]] = d[i];
        c[3] = d[0] ^ d[1] ^ d[2];
        c[5] = d[0] ^ d[1] ^ d[3];
        c[6] = d[0] ^ d[2] ^ d[3];
        if (en && pos < 3'd7) c[pos] = ~c[pos];
        return c;
    endfunction

    // Reference decoder: syndrome lookup corrects any single-bit error.
    function automatic logic [3:0] model_decode(input logic [6:0] c_in);
        logic [6:0] c = c_in;
        logic [2:0] s;
        s[0] = c[3] ^ c[0] ^ c[1] ^ c[2];
        s[1] = c[5] ^ c[0] ^ c[1] ^ c[4];
        s[2] = c[6] ^ c[0] ^ c[2] ^ c[4];
        case (s)
            3'b111: c[0] = ~c[0];
            3'b011: c[1] = ~c[1];
            3'b101: c[2] = ~c[2];
            3'b001: c[3] = ~c[3];
            3'b110: c[4] = ~c[4];
            3'b010: c[5] = ~c[5];
            3'b100: c[6] = ~c[6];
            default: ;
        endcase
        return {c[4], c[2], c[1], c[0]};
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge
    // with data_valid still high.
    task automatic send(input logic [3:0] d, input logic en, input logic [2:0] pos, output int acc_cyc);
        exp_t e;
        bus.data_in    = d;
        bus.err_en     = en;
        bus.err_pos    = pos;
        bus.data_valid = 1'b1;
        acc_cyc        = -1;
        for (int i = 0; i < 50; i++) begin
            if (bus.data_ready === 1'b1) begin
                e.cw        = model_cw(d, en, pos);
                e.data      = d;
                e.start_cyc = cyc + 1;
                sb_q.push_back(e);
                acc_cyc = cyc + 1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        if (acc_cyc < 0) fail_now("accept_timeout");
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (sb_q.size() == 0 && bus.busy === 1'b0) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!done) fail_now("drain_timeout");
    endtask

    // Monitor: collects each frame and checks it against the scoreboard.
    initial begin
        exp_t       e;
        logic [6:0] got;
        forever begin
            @(negedge clk);
            if (mon_en && bus.frame_start === 1'b1) begin
                if (sb_q.size() == 0) begin
                    fail_now("unexpected_frame");
                end else begin
                    e = sb_q.pop_front();
                    check("start_latency", cyc, e.start_cyc);
                    for (int k = 0; k < 7; k++) begin
                        if (k > 0) @(negedge clk);
                        got[k] = bus.encode_out;
                        check("frame_start_bit", {31'd0, bus.frame_start}, (k == 0) ? 1 : 0);
                        check("busy_bit", {31'd0, bus.busy}, 1);
                        check("ready_in_shift", {31'd0, bus.data_ready}, 0);
                    end
                    for (int g = 0; g < int'(GUARD_BITS); g++) begin
                        @(negedge clk);
                        check("guard_level", {31'd0, bus.encode_out}, {31'd0, IDLE_LEVEL});
                        check("guard_busy", {31'd0, bus.busy}, 1);
                        check("guard_ready", {31'd0, bus.data_ready}, (g == int'(GUARD_BITS) - 1) ? 1 : 0);
                    end
                    check("codeword", {25'd0, got}, {25'd0, e.cw});
                    check("loopback_decode", {28'd0, model_decode(got)}, {28'd0, e.data});
                end
            end else if (mon_en && bus.busy === 1'b0) begin
                check("idle_level", {31'd0, bus.encode_out}, {31'd0, IDLE_LEVEL});
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2, gap;
        bus.data_in    = 4'd0;
        bus.data_valid = 1'b0;
        bus.err_en     = 1'b0;
        bus.err_pos    = 3'd7;

        // Reset held for two edges.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_encode_out", {31'd0, bus.encode_out}, {31'd0, IDLE_LEVEL});
        check("rst_frame_start", {31'd0, bus.frame_start}, 0);
        check("rst_busy", {31'd0, bus.busy}, 0);
        check("rst_ready", {31'd0, bus.data_ready}, 1);
        rst = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;

        // Plain frame.
        send(4'b1011, 1'b0, 3'd7, a1);
        bus.data_valid = 1'b0;
        wait_idle();

        // Back-to-back with data_valid held throughout.
        send(4'hF, 1'b0, 3'd7, a1);
        send(4'h0, 1'b0, 3'd7, a2);
        bus.data_valid = 1'b0;
        check("b2b_period", a2 - a1, 7 + GUARD_BITS);
        wait_idle();

        // Error injection, then err_pos=7 (no flip).
        send(4'b1011, 1'b1, 3'd4, a1);
        bus.data_valid = 1'b0;
        send(4'b1011, 1'b1, 3'd7, a1);
        bus.data_valid = 1'b0;
        wait_idle();

        // Randomized traffic; error controls wiggle between accepts.
        for (int n = 0; n < 40; n++) begin
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                bus.data_valid = 1'b0;
                bus.data_in    = 4'($urandom);
                bus.err_en     = 1'($urandom);
                bus.err_pos    = 3'($urandom);
                @(negedge clk);
            end
            send(4'($urandom), 1'($urandom), 3'($urandom_range(0, 7)), a1);
        end
        bus.data_valid = 1'b0;
        wait_idle();

        // Reset during bit 3 aborts the frame.
        mon_en = 1'b0;
        bus.data_in    = 4'b1011;
        bus.err_en     = 1'b0;
        bus.err_pos    = 3'd7;
        bus.data_valid = 1'b1;
        @(negedge clk);
        bus.data_valid = 1'b0;
        check("abort_bit0_start", {31'd0, bus.frame_start}, 1);
        repeat (3) @(negedge clk);
        check("abort_busy_bit3", {31'd0, bus.busy}, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_encode_out", {31'd0, bus.encode_out}, {31'd0, IDLE_LEVEL});
        check("abort_busy", {31'd0, bus.busy}, 0);
        check("abort_ready", {31'd0, bus.data_ready}, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("abort_quiet_busy", {31'd0, bus.busy}, 0);
            check("abort_quiet_out", {31'd0, bus.encode_out}, {31'd0, IDLE_LEVEL});
        end

        // Reset coinciding with a transfer drops the nibble.
        bus.data_in    = 4'hA;
        bus.data_valid = 1'b1;
        rst            = 1'b1;
        @(negedge clk);
        rst            = 1'b0;
        bus.data_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rst_wins_busy", {31'd0, bus.busy}, 0);
            check("rst_wins_start", {31'd0, bus.frame_start}, 0);
            @(negedge clk);
        end

        // Encoder still works after the resets.
        mon_en = 1'b1;
        send(4'h6, 1'b1, 3'd0, a1);
        bus.data_valid = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_hamming74_serial_encoder
`default_nettype wire
